// File: rtl/kp_pkg.sv
// Shared definitions for the keypad receive path: decoder states, the idle
// row pattern and helpers that classify a synchronized row sample.
package kp_pkg;

   // Decoder states, from scanning through press and release debounce
   typedef enum logic [1:0] {
      SCANNING = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   // Row lines are active-low, so no key pressed reads as all ones
   localparam logic [3:0] ROWS_IDLE = 4'hF;

   // True when exactly one row line is pulled low; multi-row patterns are
   // ambiguous (possible ghosting) and are deliberately rejected.
   function automatic logic is_single(input logic [3:0] rows);
      logic single;
      case (rows)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
         default:                            single = 1'b0;
      endcase
      return single;
   endfunction

   // Position of the single low row line; only meaningful when is_single()
   function automatic logic [1:0] row_index(input logic [3:0] rows);
      logic [1:0] idx;
      case (rows)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the four asynchronous keypad row lines.
// Resets to the idle pattern so a reset never looks like a key press.
module kp_row_sync
   import kp_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] rows_i,
   output logic [3:0] rows_sync_o
);

   logic [3:0] stage1_q;
   logic [3:0] stage2_q;

   // Two back-to-back registers give the first stage time to resolve metastability
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage1_q <= ROWS_IDLE;
         stage2_q <= ROWS_IDLE;
      end else begin
         stage1_q <= rows_i;
         stage2_q <= stage1_q;
      end
   end

   assign rows_sync_o = stage2_q;

endmodule

// File: rtl/kp_decode.sv
// Keypad receive side: samples the row lines for the column the scanner is
// driving, freezes the scanner on a pressed key, debounces press and release
// and reports a key code with a one-cycle strobe and a held level.
// Optional auto-repeat while a key stays held is built when KP_REPEAT_EN is
// defined; without it each press yields exactly one KEY_VALID.
module kp_decode
   import kp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_DWELL      = 4
`ifdef KP_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100
`endif
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] ROWS,
   input  logic [1:0] COUNT,
   output logic       SCAN_EN,
   output logic [3:0] KEY,
   output logic       KEY_VALID,
   output logic       KEY_HELD
);

   localparam int DW_W = $clog2(SCAN_DWELL);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   kp_state_e       state_q,   state_d;
   logic [DW_W-1:0] dwellCnt_q, dwellCnt_d;
   logic [DB_W-1:0] dbCnt_q,   dbCnt_d;
   logic [3:0]      pattern_q, pattern_d;
   logic [3:0]      code_q,    code_d;
   logic [3:0]      key_q,     key_d;
   logic            valid_q,   valid_d;
   logic            held_q,    held_d;

   logic [3:0]      rowsSync;
   logic            rowsSingle;
   logic            rowsIdle;
   logic            rowsMatch;
   logic            dwellEnd;
   logic            repeatFire;

   kp_row_sync u_row_sync (
      .clk_i       (CLK),
      .rst_i       (RST),
      .rows_i      (ROWS),
      .rows_sync_o (rowsSync)
   );

   assign rowsSingle = is_single(rowsSync);
   assign rowsIdle   = (rowsSync == ROWS_IDLE);
   assign rowsMatch  = (rowsSync == pattern_q);
   assign dwellEnd   = (dwellCnt_q == DWELL_LAST);

`ifdef KP_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] repCnt_q,   repCnt_d;
   logic            repPhase_q, repPhase_d;
   logic [RP_W-1:0] repLimit;
   logic            inHold;

   assign repLimit = repPhase_q ? RP_W'(REPEAT_PERIOD - 1) : RP_W'(REPEAT_DELAY - 1);
   assign inHold   = (state_q == PRESSED) && !rowsIdle;

   // Holding the key first waits the initial delay, then repeats at the period;
   // the strobe is suppressed if it would land right after another strobe
   assign repeatFire = inHold && (repCnt_q == repLimit) && !valid_q;

   // Repeat timer only advances while the key sits in PRESSED and restarts otherwise
   always_comb begin
      repCnt_d   = repCnt_q;
      repPhase_d = repPhase_q;
      if (!inHold) begin
         repCnt_d   = '0;
         repPhase_d = 1'b0;
      end else if (repCnt_q == repLimit) begin
         repCnt_d   = '0;
         repPhase_d = 1'b1;
      end else begin
         repCnt_d   = repCnt_q + RP_W'(1);
      end
   end

   // Repeat timer registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         repCnt_q   <= '0;
         repPhase_q <= 1'b0;
      end else begin
         repCnt_q   <= repCnt_d;
         repPhase_q <= repPhase_d;
      end
   end
`else
   assign repeatFire = 1'b0;
`endif

   // Next-state logic for the scan/debounce/press/release sequence
   always_comb begin
      state_d    = state_q;
      dwellCnt_d = dwellCnt_q;
      dbCnt_d    = dbCnt_q;
      pattern_d  = pattern_q;
      code_d     = code_q;
      key_d      = key_q;
      valid_d    = 1'b0;
      held_d     = held_q;

      case (state_q)
         SCANNING: begin
            if (dwellEnd) begin
               dwellCnt_d = '0;
               if (rowsSingle) begin
                  pattern_d = rowsSync;
                  code_d    = {COUNT, row_index(rowsSync)};
                  dbCnt_d   = '0;
                  state_d   = DEBOUNCE;
               end
            end else begin
               dwellCnt_d = dwellCnt_q + DW_W'(1);
            end
         end

         DEBOUNCE: begin
            if (rowsMatch) begin
               if (dbCnt_q == DB_LAST) begin
                  state_d = PRESSED;
                  key_d   = code_q;
                  valid_d = 1'b1;
                  held_d  = 1'b1;
               end else begin
                  dbCnt_d = dbCnt_q + DB_W'(1);
               end
            end else begin
               state_d    = SCANNING;
               dwellCnt_d = '0;
            end
         end

         PRESSED: begin
            if (rowsIdle) begin
               state_d = RELEASE;
               dbCnt_d = '0;
            end else if (repeatFire) begin
               valid_d = 1'b1;
            end
         end

         RELEASE: begin
            if (rowsIdle) begin
               if (dbCnt_q == DB_LAST) begin
                  state_d    = SCANNING;
                  held_d     = 1'b0;
                  dwellCnt_d = '0;
               end else begin
                  dbCnt_d = dbCnt_q + DB_W'(1);
               end
            end else if (rowsMatch) begin
               state_d = PRESSED;
            end else begin
               dbCnt_d = '0;
            end
         end

         default: begin
            state_d    = SCANNING;
            dwellCnt_d = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= SCANNING;
         dwellCnt_q <= '0;
         dbCnt_q    <= '0;
         pattern_q  <= ROWS_IDLE;
         code_q     <= 4'h0;
         key_q      <= 4'h0;
         valid_q    <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dwellCnt_q <= dwellCnt_d;
         dbCnt_q    <= dbCnt_d;
         pattern_q  <= pattern_d;
         code_q     <= code_d;
         key_q      <= key_d;
         valid_q    <= valid_d;
         held_q     <= held_d;
      end
   end

   // The scanner advances only at the end of a dwell with no single key seen,
   // so it stays parked on the column of a key being debounced or held
   assign SCAN_EN   = (state_q == SCANNING) && dwellEnd && !rowsSingle && !RST;
   assign KEY       = key_q;
   assign KEY_VALID = valid_q;
   assign KEY_HELD  = held_q;

endmodule

// File: tb/tb_kp_decode.sv
// Testbench for kp_decode: models the column scanner and a keypad matrix,
// predicts key codes into a queue when presses are driven and pops them
// whenever the decoder strobes KEY_VALID.
module tb_kp_decode;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] ROWS;
   logic [1:0] COUNT = 2'd0;
   logic       SCAN_EN;
   logic [3:0] KEY;
   logic       KEY_VALID;
   logic       KEY_HELD;

   logic [3:0] pressMask [4];
   logic [3:0] expQ [$];
   int         vectors = 0;
   int         miscompares = 0;
   logic       prevValid = 1'b0;

   typedef struct {
      logic [1:0] col;
      logic [3:0] pattern;
      int         hold;
      logic       expValid;
      logic [3:0] expKey;
      logic       expHeld;
   } vec_t;

   vec_t vecs [7];

   kp_decode dut (
      .CLK       (CLK),
      .RST       (RST),
      .ROWS      (ROWS),
      .COUNT     (COUNT),
      .SCAN_EN   (SCAN_EN),
      .KEY       (KEY),
      .KEY_VALID (KEY_VALID),
      .KEY_HELD  (KEY_HELD)
   );

   always #5 CLK = ~CLK;

   // Column scanner: advances when enabled, restarts at column 0 on reset
   always @(posedge CLK) begin
      if (RST)          COUNT <= 2'd0;
      else if (SCAN_EN) COUNT <= COUNT + 2'd1;
   end

   // Keypad matrix: the driven column returns whatever keys are pressed on it
   always_comb ROWS = pressMask[COUNT];

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Strobe monitor: every KEY_VALID must match a predicted press
   always @(negedge CLK) begin
      if (KEY_VALID === 1'b1) begin
         checkOutput("validSpacing", {7'd0, prevValid}, 8'h00);
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedValid: got strobe with KEY=0x%0h, expected no strobe", KEY);
         end else begin
            logic [3:0] e;
            e = expQ.pop_front();
            checkOutput("validKey", {4'd0, KEY}, {4'd0, e});
         end
      end
      prevValid = KEY_VALID;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic releaseAll();
      for (int c = 0; c < 4; c++) pressMask[c] = 4'hF;
   endtask

   task automatic waitDrain(input string name, input int bound, output int waited);
      waited = 0;
      while (expQ.size() != 0 && waited < bound) begin
         step(1);
         waited++;
      end
      checkOutput(name, 8'(expQ.size()), 8'h00);
      expQ.delete();
   endtask

   task automatic countScanPulses(input int cycles, output int pulses, output int badGap);
      int last;
      last = -1;
      pulses = 0;
      badGap = 0;
      for (int i = 0; i < cycles; i++) begin
         step(1);
         if (SCAN_EN === 1'b1) begin
            pulses++;
            if (last >= 0 && (i - last) != 4) badGap++;
            last = i;
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pressMask[v.col] = v.pattern;
      if (v.expValid) expQ.push_back(v.expKey);
      step(v.hold);
      checkOutput("pressDrained", 8'(expQ.size()), 8'h00);
      expQ.delete();
      checkOutput("pressKey", {4'd0, KEY}, {4'd0, v.expKey});
      checkOutput("pressHeld", {7'd0, KEY_HELD}, {7'd0, v.expHeld});
      if (v.expHeld) checkOutput("scanFrozen", {7'd0, SCAN_EN}, 8'h00);
      releaseAll();
      step(10);
      checkOutput("releaseBounceHeld", {7'd0, KEY_HELD}, {7'd0, v.expHeld});
      step(25);
      checkOutput("releaseDoneHeld", {7'd0, KEY_HELD}, 8'h00);
      checkOutput("releaseKeyKept", {4'd0, KEY}, {4'd0, v.expKey});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses, badGap, waited;

      vecs[0] = '{col: 2'd2, pattern: 4'b1011, hold: 60, expValid: 1'b1, expKey: 4'hA, expHeld: 1'b1};
      vecs[1] = '{col: 2'd0, pattern: 4'b0111, hold: 60, expValid: 1'b1, expKey: 4'h3, expHeld: 1'b1};
      vecs[2] = '{col: 2'd3, pattern: 4'b1101, hold: 60, expValid: 1'b1, expKey: 4'hD, expHeld: 1'b1};
      vecs[3] = '{col: 2'd1, pattern: 4'b0011, hold: 60, expValid: 1'b0, expKey: 4'hD, expHeld: 1'b0};
      vecs[4] = '{col: 2'd0, pattern: 4'b1110, hold: 10, expValid: 1'b0, expKey: 4'hD, expHeld: 1'b0};
      vecs[5] = '{col: 2'd1, pattern: 4'b1110, hold: 60, expValid: 1'b1, expKey: 4'h4, expHeld: 1'b1};
      vecs[6] = '{col: 2'd3, pattern: 4'b0111, hold: 60, expValid: 1'b1, expKey: 4'hF, expHeld: 1'b1};

      releaseAll();
      RST = 1'b1;
      step(3);
      checkOutput("resetScanEn", {7'd0, SCAN_EN}, 8'h00);
      checkOutput("resetKey", {4'd0, KEY}, 8'h00);
      checkOutput("resetValid", {7'd0, KEY_VALID}, 8'h00);
      checkOutput("resetHeld", {7'd0, KEY_HELD}, 8'h00);
      RST = 1'b0;

      $display("[TB] idle scan");
      countScanPulses(200, pulses, badGap);
      checkOutput("idlePulses", 8'(pulses), 8'd50);
      checkOutput("idleGap", 8'(badGap), 8'd0);
      checkOutput("idleKey", {4'd0, KEY}, 8'h00);

      $display("[TB] vector table");
      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] bouncing press");
      for (int p = 0; p < 10; p++) begin
         pressMask[1] = (p % 2 == 0) ? 4'b1110 : 4'hF;
         step(3);
      end
      pressMask[1] = 4'b1110;
      expQ.push_back(4'h4);
      waitDrain("bounceValid", 100, waited);
      checkOutput("bounceStableTime", {7'd0, (waited >= 17)}, 8'h01);
      checkOutput("bounceKey", {4'd0, KEY}, 8'h04);
      step(10);
      releaseAll();
      step(35);
      checkOutput("bounceReleased", {7'd0, KEY_HELD}, 8'h00);

      $display("[TB] two-row pattern on every column");
      for (int c = 0; c < 4; c++) pressMask[c] = 4'b0011;
      countScanPulses(100, pulses, badGap);
      checkOutput("ghostPulses", 8'(pulses), 8'd25);
      checkOutput("ghostHeld", {7'd0, KEY_HELD}, 8'h00);
      checkOutput("ghostKeyKept", {4'd0, KEY}, 8'h04);
      releaseAll();
      step(5);

      $display("[TB] reset while pressed");
      pressMask[2] = 4'b1011;
      expQ.push_back(4'hA);
      waitDrain("preResetValid", 100, waited);
      step(5);
      RST = 1'b1;
      step(1);
      checkOutput("midResetKey", {4'd0, KEY}, 8'h00);
      checkOutput("midResetHeld", {7'd0, KEY_HELD}, 8'h00);
      checkOutput("midResetValid", {7'd0, KEY_VALID}, 8'h00);
      checkOutput("midResetScanEn", {7'd0, SCAN_EN}, 8'h00);
      RST = 1'b0;
      expQ.push_back(4'hA);
      waitDrain("postResetValid", 100, waited);
      step(30);
      checkOutput("postResetKey", {4'd0, KEY}, 8'h0A);
      checkOutput("postResetHeld", {7'd0, KEY_HELD}, 8'h01);
      releaseAll();
      step(35);
      checkOutput("postResetReleased", {7'd0, KEY_HELD}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
